// File: rtl/serial_add_sequencer_if.sv
// Operand/result handshake bundle for the bit-serial add/subtract sequencer.
interface serial_add_sequencer_if #(
   parameter int unsigned WIDTH = 8
);
   logic             IN_VALID;
   logic             IN_READY;
   logic             SUB;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] SUM;
   logic             CO;
   logic             OVF;
   logic             BUSY;

   modport master (
      output IN_VALID, SUB, A, B, OUT_READY,
      input  IN_READY, OUT_VALID, SUM, CO, OVF, BUSY
   );

   modport slave (
      input  IN_VALID, SUB, A, B, OUT_READY,
      output IN_READY, OUT_VALID, SUM, CO, OVF, BUSY
   );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor: one full-adder slice stepped LSB first over WIDTH
// bits, with valid/ready handshakes and one operation in flight.
module serial_add_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input logic                  CK,
   input logic                  RST,
   serial_add_sequencer_if.slave bus
);
   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] count;
   logic             carry;
   logic             co_q;
   logic             ovf_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;

   logic             in_ready_nx;
   logic             out_valid_nx;
   logic             busy_nx;
   logic             accept_c;
   logic             step_c;
   logic             last_c;
   logic             ha1_s_c;
   logic             ha1_c_c;
   logic             ha2_c_c;
   logic             bit_s_c;
   logic             bit_c_c;

   // Full-adder slice as two half adders plus an OR for the carry.
   always_comb begin
      ha1_s_c = sa[0] ^ sb[0];
      ha1_c_c = sa[0] & sb[0];
      bit_s_c = ha1_s_c ^ carry;
      ha2_c_c = ha1_s_c & carry;
      bit_c_c = ha1_c_c | ha2_c_c;
   end

   // State and handshake output registers.
   always_ff @(posedge CK) begin
      if (RST) begin
         state       <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_nx;
         in_ready_q  <= in_ready_nx;
         out_valid_q <= out_valid_nx;
         busy_q      <= busy_nx;
      end
   end

   // Next state; handshake outputs follow the state being entered.
   always_comb begin
      state_nx     = state;
      accept_c     = 1'b0;
      step_c       = 1'b0;
      last_c       = 1'b0;
      in_ready_nx  = 1'b0;
      out_valid_nx = 1'b0;
      busy_nx      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.IN_VALID) begin
               accept_c = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            step_c = 1'b1;
            if (count == LAST) begin
               last_c   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            if (bus.OUT_READY) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      in_ready_nx  = (state_nx == IDLE);
      out_valid_nx = (state_nx == DONE);
      busy_nx      = (state_nx != IDLE);
   end

   // Operand shift registers, carry, counter and result registers.
   always_ff @(posedge CK) begin
      if (RST) begin
         sa    <= '0;
         sb    <= '0;
         sum_q <= '0;
         count <= '0;
         carry <= 1'b0;
         co_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else if (accept_c) begin
         sa    <= bus.A;
         sb    <= bus.B ^ {WIDTH{bus.SUB}};
         carry <= bus.SUB;
         count <= '0;
      end else if (step_c) begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         sum_q <= {bit_s_c, sum_q[WIDTH-1:1]};
         carry <= bit_c_c;
         count <= count + CNT_W'(1);
         if (last_c) begin
            co_q  <= bit_c_c;
            ovf_q <= bit_c_c ^ carry;
         end
      end
   end

   assign bus.IN_READY  = in_ready_q;
   assign bus.OUT_VALID = out_valid_q;
   assign bus.BUSY      = busy_q;
   assign bus.SUM       = sum_q;
   assign bus.CO        = co_q;
   assign bus.OVF       = ovf_q;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer against an
// arithmetic reference model of add/subtract with handshake timing.
module tb_serial_add_sequencer;
   localparam int unsigned WIDTH = 8;

   logic CK = 1'b0;
   logic RST;

   serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

   serial_add_sequencer #(.WIDTH(WIDTH)) dut (
      .CK  (CK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #5 CK = ~CK;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic: unsigned result/carry and signed range check.
   function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                                  output logic [7:0] s, output logic co, output logic ovf);
      int ua, ub, sa, sb, r;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         s  = 8'(ua - ub);
         co = (ua >= ub);
         r  = sa - sb;
      end else begin
         s  = 8'(ua + ub);
         co = ((ua + ub) > 255);
         r  = sa + sb;
      end
      ovf = (r > 127) || (r < -128);
   endfunction

   // Transaction-level model: an accepted op is visible WIDTH edges later and
   // held until the consumer takes it.
   bit         m_ready    = 1'b0;
   bit         m_active   = 1'b0;
   int         m_age      = 0;
   logic [7:0] m_sum      = '0;
   logic       m_co       = 1'b0;
   logic       m_ovf      = 1'b0;
   logic [7:0] e_sum;
   logic       e_co;
   logic       e_ovf;
   longint     cyc        = 0;
   longint     acc_cyc    = 0;
   longint     prev_acc   = -1;
   bit         b2b_mode   = 1'b0;
   int         ops_done   = 0;
   bit         prev_ov    = 1'b0;

   always @(posedge CK) begin
      if (RST) begin
         m_ready  = 1'b1;
         m_active = 1'b0;
         m_age    = 0;
         m_sum    = '0;
         m_co     = 1'b0;
         m_ovf    = 1'b0;
      end else if (m_ready) begin
         if (!m_active) begin
            if (bus.IN_VALID) begin
               ref_op(bus.A, bus.B, bus.SUB, e_sum, e_co, e_ovf);
               m_active = 1'b1;
               m_age    = 0;
               acc_cyc  = cyc;
               if (b2b_mode && prev_acc >= 0)
                  chk("issue_interval", 64'(cyc - prev_acc), 64'(WIDTH + 2));
               prev_acc = cyc;
            end
         end else if (m_age < int'(WIDTH)) begin
            m_age++;
            if (m_age == int'(WIDTH)) begin
               m_sum = e_sum;
               m_co  = e_co;
               m_ovf = e_ovf;
            end
         end else if (bus.OUT_READY) begin
            m_active = 1'b0;
            ops_done++;
         end
      end
      cyc++;
   end

   // Per-cycle compare of DUT outputs against the model.
   always @(negedge CK) begin
      if (m_ready) begin
         chk("in_ready",  64'(bus.IN_READY),  64'(!m_active));
         chk("out_valid", 64'(bus.OUT_VALID), 64'(m_active && m_age == int'(WIDTH)));
         chk("busy",      64'(bus.BUSY),      64'(m_active));
         if (!m_active || m_age == int'(WIDTH)) begin
            chk("sum", 64'(bus.SUM), 64'(m_sum));
            chk("co",  64'(bus.CO),  64'(m_co));
            chk("ovf", 64'(bus.OVF), 64'(m_ovf));
         end
         if (bus.OUT_VALID && !prev_ov)
            chk("latency", 64'(cyc - acc_cyc), 64'(WIDTH + 1));
         prev_ov = bus.OUT_VALID;
      end
   end

   // One directed op with literal expectations; starts and ends at a negedge in IDLE.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input logic [7:0] es, input logic eco, input logic eovf,
                         input string name);
      int t;
      bus.A = a; bus.B = b; bus.SUB = sub;
      bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
      @(negedge CK);
      bus.IN_VALID = 1'b0;
      bus.A = 8'($urandom); bus.B = 8'($urandom); bus.SUB = 1'($urandom);
      t = 0;
      while (!bus.OUT_VALID && t < 40) begin
         @(negedge CK);
         t++;
      end
      chk({name, "_valid"},   64'(bus.OUT_VALID), 64'(1));
      chk({name, "_latency"}, 64'(t + 1), 64'(9));
      chk({name, "_sum"},     64'(bus.SUM), 64'(es));
      chk({name, "_co"},      64'(bus.CO),  64'(eco));
      chk({name, "_ovf"},     64'(bus.OVF), 64'(eovf));
      @(negedge CK);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ms;
      logic       mc, mo;
      int         t;
      int         start;

      RST = 1'b1;
      bus.IN_VALID = 1'b0; bus.A = '0; bus.B = '0; bus.SUB = 1'b0; bus.OUT_READY = 1'b0;

      // Pin the reference model to hand-worked values.
      ref_op(8'h5A, 8'h3C, 1'b0, ms, mc, mo);
      chk("model_5a_plus_3c", {54'd0, mo, mc, ms}, {54'd0, 1'b1, 1'b0, 8'h96});
      ref_op(8'hFF, 8'h01, 1'b0, ms, mc, mo);
      chk("model_ff_plus_01", {54'd0, mo, mc, ms}, {54'd0, 1'b0, 1'b1, 8'h00});
      ref_op(8'h10, 8'h20, 1'b1, ms, mc, mo);
      chk("model_10_minus_20", {54'd0, mo, mc, ms}, {54'd0, 1'b0, 1'b0, 8'hF0});
      ref_op(8'h80, 8'h01, 1'b1, ms, mc, mo);
      chk("model_80_minus_01", {54'd0, mo, mc, ms}, {54'd0, 1'b1, 1'b1, 8'h7F});

      repeat (2) @(negedge CK);
      chk("rst_in_ready",  64'(bus.IN_READY),  64'(1));
      chk("rst_out_valid", 64'(bus.OUT_VALID), 64'(0));
      chk("rst_busy",      64'(bus.BUSY),      64'(0));
      chk("rst_sum",       64'(bus.SUM),       64'(0));
      chk("rst_co",        64'(bus.CO),        64'(0));
      chk("rst_ovf",       64'(bus.OVF),       64'(0));
      RST = 1'b0;

      run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add_5a_3c");
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
      run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "add_00_00");
      run_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub_10_20");
      run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");

      // Backpressure: result held while OUT_READY is low; IN_VALID ignored.
      bus.A = 8'h33; bus.B = 8'h44; bus.SUB = 1'b0;
      bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b0;
      @(negedge CK);
      bus.A = 8'hAA; bus.B = 8'h55; bus.SUB = 1'b1;
      t = 0;
      while (!bus.OUT_VALID && t < 40) begin
         @(negedge CK);
         t++;
      end
      chk("bp_valid", 64'(bus.OUT_VALID), 64'(1));
      repeat (5) begin
         chk("bp_sum_hold",  64'(bus.SUM),      64'(8'h77));
         chk("bp_in_ready",  64'(bus.IN_READY), 64'(0));
         @(negedge CK);
      end
      bus.A = 8'h01; bus.B = 8'h01; bus.SUB = 1'b0;
      bus.OUT_READY = 1'b1;
      @(negedge CK);
      chk("bp_idle_after_xfer", 64'(bus.IN_READY), 64'(1));
      chk("bp_no_valid",        64'(bus.OUT_VALID), 64'(0));
      @(negedge CK);
      chk("bp_accept_next", 64'(bus.BUSY), 64'(1));
      bus.IN_VALID = 1'b0;
      t = 0;
      while (!bus.OUT_VALID && t < 40) begin
         @(negedge CK);
         t++;
      end
      chk("bp_next_sum", 64'(bus.SUM), 64'(8'h02));
      @(negedge CK);

      // Reset while RUN is at count 3 drops the op.
      bus.A = 8'h55; bus.B = 8'h11; bus.SUB = 1'b0; bus.IN_VALID = 1'b1;
      @(negedge CK);
      bus.IN_VALID = 1'b0;
      repeat (3) @(negedge CK);
      RST = 1'b1;
      @(negedge CK);
      RST = 1'b0;
      chk("midrst_in_ready",  64'(bus.IN_READY),  64'(1));
      chk("midrst_out_valid", 64'(bus.OUT_VALID), 64'(0));
      chk("midrst_busy",      64'(bus.BUSY),      64'(0));
      chk("midrst_sum",       64'(bus.SUM),       64'(0));
      run_op(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_rst_01_02");

      // Back-to-back issue with IN_VALID and OUT_READY held high.
      prev_acc = -1;
      b2b_mode = 1'b1;
      start = ops_done;
      bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
      t = 0;
      while (ops_done < start + 6 && t < 200) begin
         bus.A = 8'($urandom); bus.B = 8'($urandom); bus.SUB = 1'($urandom);
         @(negedge CK);
         t++;
      end
      chk("b2b_ops_done", 64'(ops_done - start >= 6), 64'(1));
      bus.IN_VALID = 1'b0;
      b2b_mode = 1'b0;
      repeat (14) @(negedge CK);

      // Random traffic with random backpressure.
      start = ops_done;
      t = 0;
      while (ops_done < start + 1000 && t < 60000) begin
         bus.A = 8'($urandom); bus.B = 8'($urandom); bus.SUB = 1'($urandom);
         bus.IN_VALID  = ($urandom_range(0, 3) != 0);
         bus.OUT_READY = ($urandom_range(0, 2) != 0);
         @(negedge CK);
         t++;
      end
      chk("random_ops_done", 64'(ops_done - start >= 1000), 64'(1));
      bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
      repeat (12) @(negedge CK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
